// File: rtl/ddr4_cmd_pkg.sv
// Shared types and constants for the DDR4 command executor and its app-command issuer.
package ddr4_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam logic [2:0] APP_CMD_WR    = 3'b000;
    localparam logic [2:0] APP_CMD_RD    = 3'b001;
    localparam int         ADDR_STEP_DEF = 8;

endpackage

// File: rtl/ddr4_app_cmd_issuer.sv
// Issues bl app commands (BL8 each) on the MIG app interface, stepping the address per accepted command.
module ddr4_app_cmd_issuer
    import ddr4_cmd_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int BL_W      = 8,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              active,
    input  logic              is_rd,
    input  logic [BL_W:0]     bl,
    input  logic              app_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic [BL_W:0]     cmd_cnt,
    output logic              last_cmd_accepted
);

    logic [ADDR_W-1:0] addr_r;
    logic              cmd_fire;

    assign app_en            = active && (cmd_cnt < bl);
    assign app_cmd           = (app_en && is_rd) ? APP_CMD_RD : APP_CMD_WR;
    assign app_addr          = app_en ? addr_r : '0;
    assign cmd_fire          = app_en && app_rdy;
    assign last_cmd_accepted = cmd_fire && ((cmd_cnt + 1'b1) == bl);

    // Address wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge ui_clk) begin
        if (rst) begin
            cmd_cnt <= '0;
            addr_r  <= '0;
        end else if (load) begin
            cmd_cnt <= '0;
            addr_r  <= load_addr;
        end else if (cmd_fire) begin
            cmd_cnt <= cmd_cnt + 1'b1;
            addr_r  <= addr_r + ADDR_W'(ADDR_STEP);
        end
    end

endmodule

// File: rtl/ddr4_cmd_exec.sv
// DDR4 command FIFO consumer: expands one FIFO command into MIG app commands and data beats.
// Optional build macro DDR4_CMD_EXEC_CALIB_GATE_EN holds requests until init_calib_complete.
module ddr4_cmd_exec
    import ddr4_cmd_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int BL_W      = 8,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [BL_W-1:0]   cmd_bl,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              rd_cmd_start,
    output logic              wr_cmd_start,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    output logic              wr_data_rd_en,
    input  logic              app_rd_data_valid,
    input  logic              init_calib_complete,
    output logic              busy,
    output logic              done
);

    state_t          state;
    logic [BL_W-1:0] bl_r;
    logic [BL_W:0]   bl_ext, cmd_cnt, data_cnt, beat_cnt;
    logic [BL_W:0]   cmd_next, data_next, beat_next;
    logic            done_r, req_ok, accept_wr, accept_rd, last_cmd;

`ifdef DDR4_CMD_EXEC_CALIB_GATE_EN
    assign req_ok = init_calib_complete;
`else
    logic unused_calib;
    assign unused_calib = init_calib_complete;
    assign req_ok       = 1'b1;
`endif

    // The done cycle blocks acceptance so pops are always at least two cycles apart.
    assign accept_wr = (state == IDLE) && req_ok && !done_r && wr_req;
    assign accept_rd = (state == IDLE) && req_ok && !done_r && rd_req && !wr_req;

    assign wr_cmd_start  = accept_wr;
    assign rd_cmd_start  = accept_rd;
    assign bl_ext        = {1'b0, bl_r};
    assign app_wdf_wren  = (state == WR) && (data_cnt < bl_ext);
    assign app_wdf_end   = app_wdf_wren;
    assign wr_data_rd_en = app_wdf_wren;
    assign busy          = (state != IDLE);
    assign done          = done_r;

    assign cmd_next  = cmd_cnt + (BL_W+1)'(app_en && app_rdy);
    assign data_next = data_cnt + (BL_W+1)'(app_wdf_wren && app_wdf_rdy);
    assign beat_next = beat_cnt + (BL_W+1)'(app_rd_data_valid);

    ddr4_app_cmd_issuer #(
        .ADDR_W    (ADDR_W),
        .BL_W      (BL_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_issuer (
        .ui_clk            (ui_clk),
        .rst               (rst),
        .load              (accept_wr || accept_rd),
        .load_addr         (cmd_addr),
        .active            ((state == WR) || (state == RD)),
        .is_rd             (state == RD),
        .bl                (bl_ext),
        .app_rdy           (app_rdy),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .cmd_cnt           (cmd_cnt),
        .last_cmd_accepted (last_cmd)
    );

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            state    <= IDLE;
            bl_r     <= '0;
            data_cnt <= '0;
            beat_cnt <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_wr || accept_rd) begin
                        bl_r     <= cmd_bl;
                        data_cnt <= '0;
                        beat_cnt <= '0;
                        if (cmd_bl == '0) done_r <= 1'b1;
                        else              state  <= accept_wr ? WR : RD;
                    end
                end
                WR: begin
                    data_cnt <= data_next;
                    if ((cmd_next == bl_ext) && (data_next == bl_ext)) begin
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                RD: begin
                    beat_cnt <= beat_next;
                    if (last_cmd) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    beat_cnt <= beat_next;
                    if (beat_next >= bl_ext) begin
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_exec.sv
// Directed self-checking bench for ddr4_cmd_exec; honours DDR4_CMD_EXEC_CALIB_GATE_EN when defined.
module tb_ddr4_cmd_exec;

    logic        ui_clk = 1'b0;
    logic        rst, rd_req, wr_req, app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete;
    logic [7:0]  cmd_bl;
    logic [28:0] cmd_addr;
    logic        rd_cmd_start, wr_cmd_start, app_en, app_wdf_wren, app_wdf_end, wr_data_rd_en, busy, done;
    logic [2:0]  app_cmd;
    logic [28:0] app_addr;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc_n = 0;
    int rd_start_cnt, wr_start_cnt, app_en_cnt, cmd_bad, end_bad, wdf_cnt, hold_bad, done_cnt, busy_cnt;
    int done_cyc, last_cmd_cyc, last_wdf_cyc, first_wdf_cyc, beat3_cyc, start_cyc;
    logic        hold_pend;
    logic [28:0] hold_addr;
    logic [2:0]  exp_cmd;
    logic [28:0] addr_q[$];

    always #5 ui_clk = ~ui_clk;

    ddr4_cmd_exec dut (
        .ui_clk(ui_clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr),
        .rd_cmd_start(rd_cmd_start), .wr_cmd_start(wr_cmd_start), .app_en(app_en), .app_cmd(app_cmd),
        .app_addr(app_addr), .app_rdy(app_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .wr_data_rd_en(wr_data_rd_en), .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(init_calib_complete), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rd_start_cnt = 0; wr_start_cnt = 0; app_en_cnt = 0; cmd_bad = 0; end_bad = 0;
        wdf_cnt = 0; hold_bad = 0; done_cnt = 0; busy_cnt = 0;
        done_cyc = -1; last_cmd_cyc = -1; last_wdf_cyc = -1; first_wdf_cyc = -1;
        hold_pend = 1'b0; hold_addr = '0;
        addr_q.delete();
    endtask

    task automatic sync();
        @(posedge ui_clk);
        #1;
        cyc_n++;
    endtask

    // Sample mid-cycle (inputs settled, away from the edge), log events, advance one clock.
    task automatic step();
        #4;
        if (rd_cmd_start) rd_start_cnt++;
        if (wr_cmd_start) wr_start_cnt++;
        if (busy) busy_cnt++;
        if (app_en) begin
            app_en_cnt++;
            if (app_cmd !== exp_cmd) cmd_bad++;
        end
        if (app_en && app_rdy) begin
            addr_q.push_back(app_addr);
            last_cmd_cyc = cyc_n;
        end
        if ((app_wdf_end !== app_wdf_wren) || (wr_data_rd_en !== app_wdf_wren)) end_bad++;
        if (app_wdf_wren && app_wdf_rdy) begin
            wdf_cnt++;
            last_wdf_cyc = cyc_n;
            if (first_wdf_cyc < 0) first_wdf_cyc = cyc_n;
        end
        if (hold_pend && (!app_en || app_addr !== hold_addr)) hold_bad++;
        hold_pend = app_en && !app_rdy;
        hold_addr = app_addr;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        sync();
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && done_cnt == 0; i++) step();
        check("done_timeout", done_cnt, 1);
    endtask

    task automatic issue(input logic is_wr, input logic [7:0] bl, input logic [28:0] addr);
        wr_req = is_wr; rd_req = !is_wr; cmd_bl = bl; cmd_addr = addr;
        start_cyc = cyc_n;
        step();
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; cmd_bl = '0; cmd_addr = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; init_calib_complete = 1'b1;
        exp_cmd = 3'b000;
        clear_log();
        sync(); sync();
        #4;
        check("reset_outputs", {app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, wr_data_rd_en,
                                busy, done, rd_cmd_start, wr_cmd_start}, '0);
        rst = 1'b0;
        sync();

        // Write bl=4 @0x100, always ready
        clear_log(); exp_cmd = 3'b000;
        issue(1'b1, 8'd4, 29'h100);
        wait_done(30);
        check("wr4_pops", wr_start_cnt, 1);
        check("wr4_ncmd", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
            check("wr4_addr0", addr_q[0], 29'h100);
            check("wr4_addr1", addr_q[1], 29'h108);
            check("wr4_addr2", addr_q[2], 29'h110);
            check("wr4_addr3", addr_q[3], 29'h118);
        end
        check("wr4_beats", wdf_cnt, 4);
        check("wr4_wdf_end", end_bad, 0);
        check("wr4_cmd_code", cmd_bad, 0);
        check("wr4_done_lat", done_cyc, start_cyc + 5);
        check("wr4_done_after_last", done_cyc, last_wdf_cyc + 1);

        // Read bl=3 @0x200, app_rdy toggling, third beat late
        clear_log(); exp_cmd = 3'b001;
        issue(1'b0, 8'd3, 29'h200);
        beat3_cyc = -1;
        for (int k = 0; k < 40 && done_cnt == 0; k++) begin
            app_rdy = (k % 2 == 0);
            app_rd_data_valid = (k == 3 || k == 5 || k == 25);
            if (k == 25) beat3_cyc = cyc_n;
            step();
        end
        app_rdy = 1'b1; app_rd_data_valid = 1'b0;
        check("rd3_done", done_cnt, 1);
        check("rd3_ncmd", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("rd3_addr1", addr_q[1], 29'h208);
            check("rd3_addr2", addr_q[2], 29'h210);
        end
        check("rd3_hold", hold_bad, 0);
        check("rd3_cmd_code", cmd_bad, 0);
        check("rd3_pops", {rd_start_cnt[15:0], wr_start_cnt[15:0]}, {16'd1, 16'd0});
        check("rd3_done_after_beat3", done_cyc, beat3_cyc + 1);

        // Write bl=4 with write data stalled for 10 cycles
        clear_log(); exp_cmd = 3'b000;
        issue(1'b1, 8'd4, 29'h300);
        for (int k = 0; k < 40 && done_cnt == 0; k++) begin
            app_wdf_rdy = (k >= 10);
            step();
        end
        app_wdf_rdy = 1'b1;
        check("wrstall_done", done_cnt, 1);
        check("wrstall_cmds_first", last_cmd_cyc < first_wdf_cyc, 1);
        check("wrstall_first_wdf", first_wdf_cyc, start_cyc + 11);
        check("wrstall_beats", wdf_cnt, 4);
        check("wrstall_done_lat", done_cyc, last_wdf_cyc + 1);

        // Both requests high: write wins
        clear_log(); exp_cmd = 3'b000;
        wr_req = 1'b1; rd_req = 1'b1; cmd_bl = 8'd2; cmd_addr = 29'h400;
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        wait_done(20);
        check("both_wr_pop", wr_start_cnt, 1);
        check("both_rd_pop", rd_start_cnt, 0);
        check("both_cmd_code", cmd_bad, 0);
        check("both_beats", wdf_cnt, 2);

        // Zero-length read, request held two cycles
        clear_log(); exp_cmd = 3'b001;
        rd_req = 1'b1; cmd_bl = 8'd0; cmd_addr = 29'h600;
        start_cyc = cyc_n;
        step(); step();
        rd_req = 1'b0;
        step();
        check("bl0_pops", rd_start_cnt, 1);
        check("bl0_done", done_cnt, 1);
        check("bl0_done_lat", done_cyc, start_cyc + 1);
        check("bl0_app_en", app_en_cnt, 0);
        check("bl0_busy", busy_cnt, 0);

        // Address wrap
        clear_log(); exp_cmd = 3'b000;
        issue(1'b1, 8'd2, 29'h1FFFFFF8);
        wait_done(20);
        if (addr_q.size() == 2) begin
            check("wrap_addr0", addr_q[0], 29'h1FFFFFF8);
            check("wrap_addr1", addr_q[1], 29'h0);
        end else check("wrap_ncmd", addr_q.size(), 2);

        // Reset mid-burst
        clear_log(); exp_cmd = 3'b000;
        issue(1'b1, 8'd8, 29'h500);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #4;
        check("rst_mid_outputs", {app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, wr_data_rd_en,
                                  busy, done, rd_cmd_start, wr_cmd_start}, '0);
        sync();
        clear_log();
        app_rd_data_valid = 1'b1;
        step(); step(); step();
        check("rst_no_done", done_cnt, 0);
        check("rst_stays_idle", busy_cnt, 0);
        exp_cmd = 3'b001;
        issue(1'b0, 8'd1, 29'h700);
        wait_done(20);
        app_rd_data_valid = 1'b0;
        check("post_rst_rd_pop", rd_start_cnt, 1);
        if (addr_q.size() == 1) check("post_rst_rd_addr", addr_q[0], 29'h700);
        else check("post_rst_rd_ncmd", addr_q.size(), 1);

        // Calibration gate
        clear_log(); exp_cmd = 3'b000;
        init_calib_complete = 1'b0;
        wr_req = 1'b1; cmd_bl = 8'd1; cmd_addr = 29'h800;
        step(); step(); step();
`ifdef DDR4_CMD_EXEC_CALIB_GATE_EN
        check("calib_gated_pop", wr_start_cnt, 0);
        check("calib_gated_busy", busy_cnt, 0);
        init_calib_complete = 1'b1;
        step();
        wr_req = 1'b0;
        wait_done(20);
        check("calib_release_pop", wr_start_cnt, 1);
`else
        wr_req = 1'b0;
        init_calib_complete = 1'b1;
        check("calib_ignored_pop", wr_start_cnt, 1);
        check("calib_ignored_done", done_cnt, 1);
`endif
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
